// File: rtl/seq_detector_param.sv
// Parametrised serial bit-sequence detector.
// Shifts qualified serial bits into a window and compares it against a
// run-time loadable pattern. It supports overlapping and non-overlapping
// matching, produces a registered one-cycle match pulse and keeps a
// saturating match counter.
module seq_detector_param #(
  parameter int                   PAT_WIDTH = 4,
  parameter logic [PAT_WIDTH-1:0] PATTERN   = 4'b1011,
  parameter int                   CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 X,
  input  logic                 EN,
  input  logic                 OVERLAP,
  input  logic [PAT_WIDTH-1:0] PAT_IN,
  input  logic                 PAT_LOAD,
  input  logic                 CLR_CNT,
  output logic                 Y,
  output logic [CNT_WIDTH-1:0] MATCH_CNT
);

  localparam int                    FILL_W    = $clog2(PAT_WIDTH + 1);
  localparam logic [FILL_W-1:0]     FILL_ZERO = FILL_W'(0);
  localparam logic [FILL_W-1:0]     FILL_ONE  = FILL_W'(1);
  localparam logic [FILL_W-1:0]     FILL_FULL = FILL_W'(PAT_WIDTH);
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [PAT_WIDTH-1:0]  WIN_ZERO  = PAT_WIDTH'(0);

  // FILL: window still collecting bits; ARMED: window full, matches possible.
  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t                 state_r;
  logic [PAT_WIDTH-1:0]   pat_r;
  logic [PAT_WIDTH-1:0]   win_r;
  logic [FILL_W-1:0]      fill_r;

  logic [PAT_WIDTH-1:0]   win_n_s;
  logic [FILL_W-1:0]      fill_n_s;
  logic                   hit_s;

  // Next window, saturating fill count, and match decision for the accepted bit.
  always_comb begin
    win_n_s  = {win_r[PAT_WIDTH-2:0], X};
    fill_n_s = FILL_FULL;
    case (state_r)
      ARMED:   fill_n_s = FILL_FULL;
      FILL:    fill_n_s = fill_r + FILL_ONE;
      default: fill_n_s = FILL_FULL;
    endcase
    if (EN && !PAT_LOAD) begin
      hit_s = (fill_n_s == FILL_FULL) && (win_n_s == pat_r);
    end else begin
      hit_s = 1'b0;
    end
  end

  // Detector FSM: pattern load, bit acceptance, window fill and match pulse.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= FILL;
      pat_r   <= PATTERN;
      win_r   <= WIN_ZERO;
      fill_r  <= FILL_ZERO;
      Y       <= 1'b0;
    end else if (PAT_LOAD) begin
      // The bit offered alongside a load is dropped; matching restarts.
      state_r <= FILL;
      pat_r   <= PAT_IN;
      win_r   <= WIN_ZERO;
      fill_r  <= FILL_ZERO;
      Y       <= 1'b0;
    end else if (EN) begin
      win_r <= win_n_s;
      Y     <= hit_s;
      if (hit_s && !OVERLAP) begin
        // Non-overlapping: the matched bits cannot be reused.
        fill_r  <= FILL_ZERO;
        state_r <= FILL;
      end else begin
        fill_r  <= fill_n_s;
        state_r <= (fill_n_s == FILL_FULL) ? ARMED : FILL;
      end
    end else begin
      Y <= 1'b0;
    end
  end

  // Saturating match counter; clear has priority over a coincident match.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      MATCH_CNT <= CNT_ZERO;
    end else if (CLR_CNT) begin
      MATCH_CNT <= CNT_ZERO;
    end else if (hit_s && (MATCH_CNT != CNT_MAX)) begin
      MATCH_CNT <= MATCH_CNT + CNT_ONE;
    end else begin
      MATCH_CNT <= MATCH_CNT;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed testbench for seq_detector_param: default 1011 detector plus a
// 2-bit-counter / 1111 instance for saturation and clear checks.
module tb_seq_detector_param;

  logic       clk;
  logic       rst;
  logic       x, en, overlap, pat_load, clr_cnt;
  logic [3:0] pat_in;
  logic       y;
  logic [7:0] cnt;

  logic       x6, en6, overlap6, pat_load6, clr6;
  logic [3:0] pat_in6;
  logic       y6;
  logic [1:0] cnt6;

  int passed = 0;
  int total  = 0;

  seq_detector_param #(.PAT_WIDTH(4), .PATTERN(4'b1011), .CNT_WIDTH(8)) dut (
    .CLK(clk), .RESET(rst), .X(x), .EN(en), .OVERLAP(overlap),
    .PAT_IN(pat_in), .PAT_LOAD(pat_load), .CLR_CNT(clr_cnt),
    .Y(y), .MATCH_CNT(cnt)
  );

  seq_detector_param #(.PAT_WIDTH(4), .PATTERN(4'b1111), .CNT_WIDTH(2)) dut6 (
    .CLK(clk), .RESET(rst), .X(x6), .EN(en6), .OVERLAP(overlap6),
    .PAT_IN(pat_in6), .PAT_LOAD(pat_load6), .CLR_CNT(clr6),
    .Y(y6), .MATCH_CNT(cnt6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic xb, input logic enb);
    x  = xb;
    en = enb;
    @(posedge clk);
    #1;
  endtask

  task automatic step6(input logic xb, input logic enb);
    x6  = xb;
    en6 = enb;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] s;
    overlap = 1'b1;
    pulse_reset();
    s = 4'b1011;
    for (int i = 3; i >= 0; i--) step(s[i], 1'b1);
    total++; if (y !== 1'b1) $display("FAIL reset_pre_y: got %b want 1", y); else passed++;
    total++; if (cnt !== 8'd1) $display("FAIL reset_pre_cnt: got %0d want 1", cnt); else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++; if (y !== 1'b0) $display("FAIL reset_async_y: got %b want 0", y); else passed++;
    total++; if (cnt !== 8'd0) $display("FAIL reset_async_cnt: got %0d want 0", cnt); else passed++;
    rst = 1'b0;
    s = 4'b1011;
    for (int i = 3; i >= 1; i--) begin
      step(s[i], 1'b1);
      total++; if (y !== 1'b0) $display("FAIL reset_refill_y bit%0d: got %b want 0", 4 - i, y); else passed++;
    end
    step(1'b1, 1'b1);
    total++; if (y !== 1'b1) $display("FAIL reset_refill_hit: got %b want 1", y); else passed++;
  endtask

  task automatic test_overlap();
    logic [6:0] s, e;
    pulse_reset();
    overlap = 1'b1;
    s = 7'b1011011;
    e = 7'b0001001;
    for (int i = 6; i >= 0; i--) begin
      step(s[i], 1'b1);
      total++; if (y !== e[i]) $display("FAIL overlap_y bit%0d: got %b want %b", 7 - i, y, e[i]); else passed++;
    end
    total++; if (cnt !== 8'd2) $display("FAIL overlap_cnt: got %0d want 2", cnt); else passed++;
    step(1'b0, 1'b0);
    total++; if (y !== 1'b0) $display("FAIL overlap_pulse_width: got %b want 0", y); else passed++;
  endtask

  task automatic test_non_overlap();
    logic [10:0] s, e;
    pulse_reset();
    overlap = 1'b0;
    s = 11'b1011011_1011;
    e = 11'b0001000_0001;
    for (int i = 10; i >= 0; i--) begin
      step(s[i], 1'b1);
      total++; if (y !== e[i]) $display("FAIL nonoverlap_y bit%0d: got %b want %b", 11 - i, y, e[i]); else passed++;
      if (i == 4) begin
        total++; if (cnt !== 8'd1) $display("FAIL nonoverlap_cnt_mid: got %0d want 1", cnt); else passed++;
      end
    end
    total++; if (cnt !== 8'd2) $display("FAIL nonoverlap_cnt: got %0d want 2", cnt); else passed++;
  endtask

  task automatic test_en_gaps();
    pulse_reset();
    overlap = 1'b1;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      total++; if (y !== 1'b0) $display("FAIL gap_y cyc%0d: got %b want 0", i, y); else passed++;
    end
    step(1'b1, 1'b1);
    total++; if (y !== 1'b0) $display("FAIL gap_y_bit3: got %b want 0", y); else passed++;
    step(1'b1, 1'b1);
    total++; if (y !== 1'b1) $display("FAIL gap_y_final: got %b want 1", y); else passed++;
    total++; if (cnt !== 8'd1) $display("FAIL gap_cnt: got %0d want 1", cnt); else passed++;
  endtask

  task automatic test_pat_load();
    logic [3:0] s, e;
    // Window still holds 1011 from the previous test; counter holds 1.
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    pat_in   = 4'b0110;
    pat_load = 1'b1;
    step(1'b1, 1'b1);
    pat_load = 1'b0;
    total++; if (y !== 1'b0) $display("FAIL load_y: got %b want 0", y); else passed++;
    total++; if (cnt !== 8'd1) $display("FAIL load_keeps_cnt: got %0d want 1", cnt); else passed++;
    s = 4'b0110;
    e = 4'b0001;
    for (int i = 3; i >= 0; i--) begin
      step(s[i], 1'b1);
      total++; if (y !== e[i]) $display("FAIL load_new_y bit%0d: got %b want %b", 4 - i, y, e[i]); else passed++;
    end
    total++; if (cnt !== 8'd2) $display("FAIL load_new_cnt: got %0d want 2", cnt); else passed++;
  endtask

  task automatic test_saturate();
    logic [1:0] e;
    pulse_reset();
    overlap6 = 1'b1;
    for (int b = 1; b <= 24; b++) begin
      step6(1'b1, 1'b1);
      total++; if (y6 !== (b >= 4)) $display("FAIL sat_y bit%0d: got %b want %b", b, y6, (b >= 4)); else passed++;
      if (b <= 7) begin
        e = (b < 4) ? 2'd0 : ((b - 3 > 3) ? 2'd3 : 2'(b - 3));
        total++; if (cnt6 !== e) $display("FAIL sat_cnt bit%0d: got %0d want %0d", b, cnt6, e); else passed++;
      end
    end
    total++; if (cnt6 !== 2'd3) $display("FAIL sat_cnt_end: got %0d want 3", cnt6); else passed++;
    clr6 = 1'b1;
    step6(1'b1, 1'b1);
    clr6 = 1'b0;
    total++; if (cnt6 !== 2'd0) $display("FAIL clr_with_hit: got %0d want 0", cnt6); else passed++;
    step6(1'b1, 1'b1);
    total++; if (cnt6 !== 2'd1) $display("FAIL cnt_after_clr: got %0d want 1", cnt6); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    x = 1'b0; en = 1'b0; overlap = 1'b1; pat_load = 1'b0; clr_cnt = 1'b0; pat_in = 4'b0000;
    x6 = 1'b0; en6 = 1'b0; overlap6 = 1'b1; pat_load6 = 1'b0; clr6 = 1'b0; pat_in6 = 4'b0000;
    #12;
    total++; if (y !== 1'b0) $display("FAIL init_y: got %b want 0", y); else passed++;
    total++; if (cnt !== 8'd0) $display("FAIL init_cnt: got %0d want 0", cnt); else passed++;
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_overlap();
    test_non_overlap();
    test_en_gaps();
    test_pat_load();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
